// File: rtl/logic_unit_serial.sv
// logic_unit_serial
//   Serial bitwise logic unit for the ALU logical path. A start request
//   latches two WIDTH-bit operands and a 3-bit opcode, then the selected
//   function is evaluated CHUNK bits per clock (LSB slice first) from 1-bit
//   gate primitives. The result, zero flag and a one-cycle done pulse are
//   published together on the edge that computes the last slice.
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  request, honoured while idle (and on the completion edge)
//   op     000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR,
//          110 NOT a, 111 a AND NOT b
//   a, b   operands, sampled with start
//   busy   operation in progress
//   done   one-cycle pulse, out/zero newly updated
//   out    result register
//   zero   high when out == 0
module logic_unit_serial #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             zero
);

   localparam int NSLICE = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

   generate
      if (CHUNK <= 0 || WIDTH <= 0 || ((CHUNK > 0) ? (WIDTH % CHUNK) : 1) != 0) begin : g_bad_param
         $error("logic_unit_serial: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic               zero_q, zero_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2:0]         op_q, op_d;
   logic [WIDTH-1:0]   work_q, work_d;

   logic [CHUNK-1:0]   a_s, b_s, res_s;
   logic [CHUNK-1:0]   and_s, or_s, xor_s, na_s, nb_s;
   logic [CHUNK-1:0]   nand_s, nor_s, xnor_s, andn_s;
   logic [WIDTH-1:0]   result;
   logic               accept;

   // Current operand slice, selected by the slice index.
   always_comb begin
      a_s = '0;
      b_s = '0;
      for (int k = 0; k < NSLICE; k++) begin
         if (idx_q == IDX_W'(k)) begin
            a_s = a_q[k*CHUNK +: CHUNK];
            b_s = b_q[k*CHUNK +: CHUNK];
         end
      end
   end

   // Inverting functions are built from a base gate followed by an inverter.
   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      and u_and   (and_s[i],  a_s[i], b_s[i]);
      or  u_or    (or_s[i],   a_s[i], b_s[i]);
      xor u_xor   (xor_s[i],  a_s[i], b_s[i]);
      not u_na    (na_s[i],   a_s[i]);
      not u_nb    (nb_s[i],   b_s[i]);
      not u_nand  (nand_s[i], and_s[i]);
      not u_nor   (nor_s[i],  or_s[i]);
      not u_xnor  (xnor_s[i], xor_s[i]);
      and u_andn  (andn_s[i], a_s[i], nb_s[i]);
   end

   always_comb begin
      case (op_q)
         3'b000:  res_s = and_s;
         3'b001:  res_s = or_s;
         3'b010:  res_s = xor_s;
         3'b011:  res_s = nand_s;
         3'b100:  res_s = nor_s;
         3'b101:  res_s = xnor_s;
         3'b110:  res_s = na_s;
         default: res_s = andn_s;
      endcase
   end

   // Work register with the freshly computed slice merged in.
   always_comb begin
      result = work_q;
      for (int k = 0; k < NSLICE; k++) begin
         if (idx_q == IDX_W'(k)) begin
            result[k*CHUNK +: CHUNK] = res_s;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      out_d   = out_q;
      zero_d  = zero_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      work_d  = work_q;
      accept  = 1'b0;

      case (state_q)
         S_IDLE: accept = start;
         S_RUN: begin
            work_d = result;
            idx_d  = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
               out_d   = result;
               zero_d  = (result == '0);
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
               idx_d   = '0;
               // The completion edge also serves as an idle sampling point,
               // so a request presented in the last cycle chains with no gap.
               accept  = start;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         a_d     = a;
         b_d     = b;
         op_d    = op;
         work_d  = '0;
         idx_d   = '0;
         busy_d  = 1'b1;
         state_d = S_RUN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         out_q   <= '0;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         out_q   <= out_d;
         zero_q  <= zero_d;
      end
   end

   // Operand and work storage carry no reset; they are always loaded on accept.
   always_ff @(posedge clk) begin
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      work_q <= work_d;
   end

   assign busy = busy_q;
   assign done = done_q;
   assign out  = out_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_logic_unit_serial.sv
// tb_logic_unit_serial
//   Scoreboard bench for logic_unit_serial in three configurations:
//   32/8 (main), 16/16 (single-cycle, back-to-back) and 64/4 (16 slices).
module tb_logic_unit_serial;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        start0, busy0, done0, zero0;
   logic [2:0]  op0;
   logic [31:0] a0, b0, out0;

   logic        start1, busy1, done1, zero1;
   logic [2:0]  op1;
   logic [15:0] a1, b1, out1;

   logic        start2, busy2, done2, zero2;
   logic [2:0]  op2;
   logic [63:0] a2, b2, out2;

   logic_unit_serial #(.WIDTH(32), .CHUNK(8)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .op(op0), .a(a0), .b(b0),
      .busy(busy0), .done(done0), .out(out0), .zero(zero0));

   logic_unit_serial #(.WIDTH(16), .CHUNK(16)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .op(op1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .out(out1), .zero(zero1));

   logic_unit_serial #(.WIDTH(64), .CHUNK(4)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .op(op2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .out(out2), .zero(zero2));

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] q0[$];
   logic [15:0] q1[$];
   logic [63:0] q2[$];
   logic [31:0] prev0 = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_op(input logic [2:0] f, input logic [63:0] x, input logic [63:0] y);
      logic [63:0] r;
      case (f)
         3'd0:    r = x & y;
         3'd1:    r = x | y;
         3'd2:    r = x ^ y;
         3'd3:    r = ~(x & y);
         3'd4:    r = ~(x | y);
         3'd5:    r = ~(x ^ y);
         3'd6:    r = ~x;
         default: r = x & ~y;
      endcase
      return r;
   endfunction

   // Scoreboard pops: every done must match the oldest outstanding request.
   always @(negedge clk) begin : mon0
      logic [31:0] e;
      if (done0) begin
         if (q0.size() == 0) check("d0_spurious_done", 64'(done0), 64'd0);
         else begin
            e = q0.pop_front();
            check("d0_out", 64'(out0), 64'(e));
            check("d0_zero", 64'(zero0), 64'(e == 32'd0));
         end
      end
   end

   always @(negedge clk) begin : mon1
      logic [15:0] e;
      if (done1) begin
         if (q1.size() == 0) check("d1_spurious_done", 64'(done1), 64'd0);
         else begin
            e = q1.pop_front();
            check("d1_out", 64'(out1), 64'(e));
            check("d1_zero", 64'(zero1), 64'(e == 16'd0));
         end
      end
   end

   always @(negedge clk) begin : mon2
      logic [63:0] e;
      if (done2) begin
         if (q2.size() == 0) check("d2_spurious_done", 64'(done2), 64'd0);
         else begin
            e = q2.pop_front();
            check("d2_out", out2, e);
            check("d2_zero", 64'(zero2), 64'(e == 64'd0));
         end
      end
   end

   task automatic run0(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp, input bit perturb);
      int lat;
      @(negedge clk);
      a0 = av; b0 = bv; op0 = f; start0 = 1'b1;
      q0.push_back(exp);
      @(negedge clk);
      start0 = 1'b0;
      check("d0_busy", 64'(busy0), 64'd1);
      check("d0_out_hold", 64'(out0), 64'(prev0));
      lat = 0;
      while (!done0 && lat < 100) begin
         @(negedge clk);
         lat++;
         if (perturb && lat == 1) begin
            a0 = ~av; b0 = ~bv; op0 = f ^ 3'b101; start0 = 1'b1;
         end else begin
            start0 = 1'b0;
         end
      end
      check("d0_latency", 64'(lat), 64'd4);
      prev0 = exp;
   endtask

   task automatic run2(input logic [2:0] f, input logic [63:0] av, input logic [63:0] bv);
      int lat;
      @(negedge clk);
      a2 = av; b2 = bv; op2 = f; start2 = 1'b1;
      q2.push_back(ref_op(f, av, bv));
      @(negedge clk);
      start2 = 1'b0;
      check("d2_busy", 64'(busy2), 64'd1);
      lat = 0;
      while (!done2 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check("d2_latency", 64'(lat), 64'd16);
   endtask

   logic [31:0] sweep_exp [8] = '{32'hF000000F, 32'hFFF00FFF, 32'h0FF00FF0, 32'h0FFFFFF0,
                                  32'h000FF000, 32'hF00FF00F, 32'h0F0FFF00, 32'h00F000F0};

   initial begin
      logic [63:0] r;
      rst = 1'b1;
      start0 = 1'b0; op0 = '0; a0 = '0; b0 = '0;
      start1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;
      start2 = 1'b0; op2 = '0; a2 = '0; b2 = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy0), 64'd0);
      check("rst_done", 64'(done0), 64'd0);
      check("rst_out", 64'(out0), 64'd0);
      check("rst_zero", 64'(zero0), 64'd1);
      check("rst_zero1", 64'(zero1), 64'd1);
      check("rst_zero2", 64'(zero2), 64'd1);
      rst = 1'b0;

      // Main configuration: directed cases.
      run0(3'b011, 32'hCA981547, 32'h3567EAB8, 32'hFFFFFFFF, 1'b0);
      run0(3'b000, 32'hCA981547, 32'h3567EAB8, 32'h00000000, 1'b0);
      run0(3'b010, 32'hCA981547, 32'h3567EAB8, 32'hFFFFFFFF, 1'b0);
      run0(3'b011, 32'h3567EAB8, 32'h3567EAB8, 32'hCA981547, 1'b1);
      for (int i = 0; i < 8; i++)
         run0(3'(i), 32'hF0F000FF, 32'hFF000F0F, sweep_exp[i], 1'b0);
      @(negedge clk);
      check("d0_done_one_cycle", 64'(done0), 64'd0);

      // Asynchronous reset two cycles into an operation.
      @(negedge clk);
      a0 = 32'h12345678; b0 = 32'h0F0F0F0F; op0 = 3'b001; start0 = 1'b1;
      q0.push_back(32'h1F3F5F7F);
      @(negedge clk);
      start0 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("arst_busy", 64'(busy0), 64'd0);
      check("arst_done", 64'(done0), 64'd0);
      check("arst_out", 64'(out0), 64'd0);
      check("arst_zero", 64'(zero0), 64'd1);
      q0.delete();
      prev0 = '0;
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check("arst_no_done", 64'(done0), 64'd0);
      run0(3'b111, 32'hDEADBEEF, 32'h0000FFFF, 32'hDEAD0000, 1'b0);

      // Single-slice configuration: one-cycle latency, then held start.
      @(negedge clk);
      a1 = 16'hA5C3; b1 = 16'h0FF0; op1 = 3'b101; start1 = 1'b1;
      r = ref_op(3'b101, 64'(16'hA5C3), 64'(16'h0FF0));
      q1.push_back(r[15:0]);
      @(negedge clk);
      start1 = 1'b0;
      check("d1_busy", 64'(busy1), 64'd1);
      check("d1_done_early", 64'(done1), 64'd0);
      @(negedge clk);
      check("d1_done_lat1", 64'(done1), 64'd1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i >= 2) check("d1_b2b_done", 64'(done1), 64'd1);
         a1 = 16'($urandom); b1 = 16'($urandom); op1 = 3'($urandom_range(0, 7));
         start1 = 1'b1;
         r = ref_op(op1, 64'(a1), 64'(b1));
         q1.push_back(r[15:0]);
      end
      @(negedge clk);
      check("d1_b2b_done", 64'(done1), 64'd1);
      start1 = 1'b0;
      @(negedge clk);
      check("d1_b2b_last", 64'(done1), 64'd1);
      @(negedge clk);
      check("d1_idle_after", 64'(done1), 64'd0);

      // Sixteen-slice configuration.
      run2(3'b100, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
      for (int i = 0; i < 8; i++)
         run2(3'(i), {$urandom, $urandom}, {$urandom, $urandom});

      repeat (3) @(negedge clk);
      check("queues_drained", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1);
   end

endmodule
